ccff_loader: RTL

Configuration-chain programming controller that sits directly upstream of the fabric's configuration flip-flop chain, driving the `ccff_head` of the first tile and gating `prog_clk` for the whole chain. It accepts the bitstream as bytes over a valid/ready handshake, serializes them MSB-first into the chain, and counts exactly `CHAIN_LEN` shifts. As a compile-time option, it verifies a second pass of the same stream against the bits emerging at the chain's `ccff_tail`.

---
 rtl/ccff_pkg.sv | 18 +
 rtl/ccff_serializer.sv | 83 ++++++++
 rtl/ccff_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
// State encoding, byte width, and byte count for a chain of a given length.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } ccff_state_t;

    localparam int CCFF_BYTE_W = 8;

    function automatic int ccff_num_bytes(input int chain_len);
        return (chain_len + CCFF_BYTE_W - 1) / CCFF_BYTE_W;
    endfunction

endpackage

// File: rtl/ccff_serializer.sv
// Byte-to-bit serializer, MSB first: a byte taken at edge M loads the shift register at edge M+1.
// byte_rdy is low while the holding byte is full; bit_vld drops when both the holding byte and the shift register are empty.
module ccff_serializer
    import ccff_pkg::*;
(
    input  logic                   prog_clk,
    input  logic                   prog_reset,
    input  logic                   clr,
    input  logic                   byte_vld,
    input  logic [CCFF_BYTE_W-1:0] byte_dat,
    input  logic                   byte_last,
    output logic                   byte_rdy,
    input  logic [3:0]             last_partial,
    output logic                   bit_vld,
    output logic                   bit_dat
);

    logic                   buf_vld_q, buf_vld_d;
    logic                   buf_last_q, buf_last_d;
    logic [CCFF_BYTE_W-1:0] buf_dat_q, buf_dat_d;
    logic [CCFF_BYTE_W-1:0] sr_q, sr_d;
    logic [3:0]             sr_cnt_q, sr_cnt_d;
    logic                   bit_vld_q, bit_vld_d;

    assign byte_rdy = ~buf_vld_q;
    assign bit_vld  = bit_vld_q;
    assign bit_dat  = sr_q[CCFF_BYTE_W-1];

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_last_d = buf_last_q;
        buf_dat_d  = buf_dat_q;
        sr_d       = sr_q;
        sr_cnt_d   = sr_cnt_q;

        if (bit_vld_q) begin
            sr_d     = {sr_q[CCFF_BYTE_W-2:0], 1'b0};
            sr_cnt_d = sr_cnt_q - 4'd1;
        end

        // Reload on the same edge the last bit leaves, so a held byte streams without a bubble.
        if (buf_vld_q && (sr_cnt_d == 4'd0)) begin
            sr_d      = buf_dat_q;
            sr_cnt_d  = buf_last_q ? last_partial : 4'd8;
            buf_vld_d = 1'b0;
        end

        if (byte_vld && !buf_vld_q) begin
            buf_vld_d  = 1'b1;
            buf_dat_d  = byte_dat;
            buf_last_d = byte_last;
        end

        if (clr) begin
            buf_vld_d  = 1'b0;
            buf_last_d = 1'b0;
            buf_dat_d  = '0;
            sr_d       = '0;
            sr_cnt_d   = 4'd0;
        end

        bit_vld_d = (sr_cnt_d != 4'd0);
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            buf_vld_q  <= 1'b0;
            buf_last_q <= 1'b0;
            buf_dat_q  <= '0;
            sr_q       <= '0;
            sr_cnt_q   <= 4'd0;
            bit_vld_q  <= 1'b0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_last_q <= buf_last_d;
            buf_dat_q  <= buf_dat_d;
            sr_q       <= sr_d;
            sr_cnt_q   <= sr_cnt_d;
            bit_vld_q  <= bit_vld_d;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Config-chain loader: CHAIN_LEN bits onto ccff_head after a 2-cycle fill, 1 bit/cycle; the chain holds when no byte is available.
// CCFF_READBACK_EN adds a VERIFY pass that resends the stream and flags ccff_tail != ccff_head in sticky cfg_error.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 256,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                   prog_clk,
    input  logic                   prog_reset,
    input  logic                   cfg_start,
    input  logic [CCFF_BYTE_W-1:0] cfg_data,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   ccff_head,
    output logic                   ccff_shift_en,
    input  logic                   ccff_tail,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_error
);

    localparam int NBYTES = ccff_num_bytes(CHAIN_LEN);
    localparam int BCNT_W = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BCNT_W-1:0] NBYTES_C   = BCNT_W'(NBYTES);
    localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(NBYTES - 1);
    localparam logic [3:0]        LAST_BITS  = 4'(CHAIN_LEN - (NBYTES - 1) * CCFF_BYTE_W);

    ccff_state_t       state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ser_clr;
    logic              byte_ok;
    logic              byte_rdy;
    logic              bit_vld;
    logic              bit_dat;

    assign byte_ok       = busy_q && (byte_cnt_q < NBYTES_C);
    assign cfg_ready     = byte_ok & byte_rdy;
    assign ccff_head     = bit_dat;
    assign ccff_shift_en = bit_vld;
    assign cfg_busy      = busy_q;
    assign cfg_done      = done_q;

`ifdef CCFF_READBACK_EN
    logic err_q, err_d;
    assign cfg_error = err_q;
`else
    logic tail_unused;
    assign tail_unused = ccff_tail;
    assign cfg_error   = 1'b0;
`endif

    ccff_serializer u_ser (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .clr          (ser_clr),
        .byte_vld     (cfg_valid & byte_ok),
        .byte_dat     (cfg_data),
        .byte_last    (byte_cnt_q == LAST_BYTE),
        .byte_rdy     (byte_rdy),
        .last_partial (LAST_BITS),
        .bit_vld      (bit_vld),
        .bit_dat      (bit_dat)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ser_clr    = 1'b0;
`ifdef CCFF_READBACK_EN
        err_d      = err_q;
`endif

        if (cfg_valid && cfg_ready) begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cfg_start) begin
                    state_d    = ST_LOAD;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    ser_clr    = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
`ifdef CCFF_READBACK_EN
                    err_d      = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (bit_vld) begin
                    if (bit_cnt_q == LAST_SHIFT) begin
                        bit_cnt_d = '0;
`ifdef CCFF_READBACK_EN
                        state_d    = ST_VERIFY;
                        byte_cnt_d = '0;
`else
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef CCFF_READBACK_EN
            ST_VERIFY: begin
                if (bit_vld) begin
                    // The tail shows the bit loaded CHAIN_LEN shifts ago, i.e. this bit's first-pass twin.
                    if (ccff_tail != bit_dat) begin
                        err_d = 1'b1;
                    end
                    if (bit_cnt_q == LAST_SHIFT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CCFF_READBACK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef CCFF_READBACK_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule
